// File: rtl/detect_pattern_seq.sv
// -----------------------------------------------------------------------------
// detect_pattern_seq
//
// Purpose:
//   Serial pattern detector. Qualified bits (bit_valid=1) are shifted into a
//   history register and compared against a run-time reloadable PAT_LEN-bit
//   pattern. A registered one-cycle pulse on `indicator` follows the edge
//   that accepted the completing bit. Overlapping and non-overlapping match
//   modes are selected per cycle by overlap_en.
//
// Parameters:
//   PAT_LEN  pattern length in bits, 2..32
//   PATTERN  reset value of the pattern register (bit PAT_LEN-1 = oldest bit)
//   CNT_W    width of the optional match counter
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   bitin        in   serial data bit
//   bit_valid    in   qualifies bitin this cycle
//   overlap_en   in   1 = overlapping matches, 0 = non-overlapping
//   pat_load     in   load pat_data into the pattern register (highest priority)
//   pat_data     in   new pattern value, PAT_LEN bits
//   count_clr    in   synchronous clear of match_count   (DETECT_PATTERN_CNT_EN)
//   match_count  out  saturating match counter, CNT_W    (DETECT_PATTERN_CNT_EN)
//   indicator    out  registered match pulse
//
// Optional feature macro: DETECT_PATTERN_CNT_EN (adds count_clr/match_count).
// -----------------------------------------------------------------------------
module detect_pattern_seq #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = '0,
    parameter int                 CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               bitin,
    input  logic               bit_valid,
    input  logic               overlap_en,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_data,
`ifdef DETECT_PATTERN_CNT_EN
    input  logic               count_clr,
    output logic [CNT_W-1:0]   match_count,
`endif
    output logic               indicator
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
    // One bit short of full: the incoming bit completes the window.
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_LEN - 1);

    generate
        if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
            $error("detect_pattern_seq: PAT_LEN must be in 2..32");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("detect_pattern_seq: CNT_W must be at least 1");
        end
    endgenerate

    logic [PAT_LEN-1:0] r_hist;
    logic [PAT_LEN-1:0] r_pat;
    logic [FILL_W-1:0]  r_fill;
    logic               r_ind;
    logic [PAT_LEN-1:0] w_cand;
    logic               w_match;

    // Candidate window: history shifted left by one with the new bit at bit 0.
    assign w_cand[0] = bitin;
    generate
        for (genvar gi = 1; gi < PAT_LEN; gi++) begin : g_cand
            assign w_cand[gi] = r_hist[gi-1];
        end
    endgenerate

    // A match only exists on an accepted bit; pat_load discards the bit.
    assign w_match = bit_valid && !pat_load &&
                     (r_fill >= FILL_THR) && (w_cand == r_pat);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= PATTERN;
            r_ind  <= 1'b0;
        end else if (pat_load) begin
            r_pat  <= pat_data;
            r_hist <= '0;
            r_fill <= '0;
            r_ind  <= 1'b0;
        end else if (bit_valid) begin
            r_hist <= w_cand;
            r_ind  <= w_match;
            // Non-overlapping mode restarts the fill so the next match
            // needs a full window of fresh bits.
            if (w_match && !overlap_en) begin
                r_fill <= '0;
            end else if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end else begin
            r_ind <= 1'b0;
        end
    end

    assign indicator = r_ind;

`ifdef DETECT_PATTERN_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating counter; clear wins over a same-edge increment.
    // pat_load deliberately leaves it untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (count_clr) begin
            r_cnt <= '0;
        end else if (w_match && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_count = r_cnt;
`endif

endmodule

// File: tb/tb_detect_pattern_seq.sv
module tb_detect_pattern_seq;

    localparam int PAT_LEN = 3;
    localparam int CNT_W   = 2;

    logic               clock;
    logic               reset;
    logic               bitin;
    logic               bit_valid;
    logic               overlap_en;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_data;
    logic               indicator;
`ifdef DETECT_PATTERN_CNT_EN
    logic               count_clr;
    logic [CNT_W-1:0]   match_count;
`endif

    detect_pattern_seq #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (3'b000),
        .CNT_W   (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bitin       (bitin),
        .bit_valid   (bit_valid),
        .overlap_en  (overlap_en),
        .pat_load    (pat_load),
        .pat_data    (pat_data),
`ifdef DETECT_PATTERN_CNT_EN
        .count_clr   (count_clr),
        .match_count (match_count),
`endif
        .indicator   (indicator)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic               valid;
        logic               bitv;
        logic               ovl;
        logic               load;
        logic [PAT_LEN-1:0] data;
        logic               exp_ind;
    } vec_t;

    vec_t tbl[$];
    logic exp_q[$];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s act=%0h exp=%0h", name, act, exp);
        end else begin
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic b, input logic o, input logic l,
                       input logic [PAT_LEN-1:0] d, input logic e);
        vec_t t;
        t.valid = v; t.bitv = b; t.ovl = o; t.load = l; t.data = d; t.exp_ind = e;
        tbl.push_back(t);
    endtask

    // Drive one cycle of stimulus, queue its expected pulse, and compare
    // just after the edge that should produce it.
    task automatic step(input string name, input logic v, input logic b, input logic o,
                        input logic l, input logic [PAT_LEN-1:0] d, input logic e);
        logic exp_v;
        bit_valid  = v;
        bitin      = b;
        overlap_en = o;
        pat_load   = l;
        pat_data   = d;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        exp_v = exp_q.pop_front();
        check(name, {31'd0, indicator}, {31'd0, exp_v});
    endtask

    int stream1[15] = '{1,1,0,0,1,0,0,0,1,1,0,0,0,0,0};
    int exp1[15]    = '{0,0,0,0,0,0,0,1,0,0,0,0,1,1,1};
    int exp2[16]    = '{0,0,0,0,0,0,0,1,0,0,0,0,1,0,0,1};
    int stream3[5]  = '{1,0,1,0,1};
    int exp3o[5]    = '{0,0,1,0,1};
    int exp3n[5]    = '{0,0,1,0,0};

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b0;
        bitin = 1'b0;
        bit_valid = 1'b0;
        overlap_en = 1'b1;
        pat_load = 1'b0;
        pat_data = '0;
`ifdef DETECT_PATTERN_CNT_EN
        count_clr = 1'b0;
`endif

        // Overlapping, default pattern 000 (reload clears history and fill).
        add(0, 0, 1, 1, 3'b000, 0);
        for (int i = 0; i < 15; i++) add(1, stream1[i][0], 1, 0, 3'b000, exp1[i][0]);
        // Non-overlapping, same stream plus one extra 0.
        add(0, 0, 0, 1, 3'b000, 0);
        for (int i = 0; i < 16; i++)
            add(1, (i < 15) ? stream1[i][0] : 1'b0, 0, 0, 3'b000, exp2[i][0]);
        // Pattern 101 in both modes.
        add(0, 0, 1, 1, 3'b101, 0);
        for (int i = 0; i < 5; i++) add(1, stream3[i][0], 1, 0, 3'b000, exp3o[i][0]);
        add(0, 0, 0, 1, 3'b101, 0);
        for (int i = 0; i < 5; i++) add(1, stream3[i][0], 0, 0, 3'b000, exp3n[i][0]);
        // Zeros separated by two idle cycles; pulse after third accepted bit only.
        add(0, 0, 1, 1, 3'b000, 0);
        for (int i = 0; i < 3; i++) begin
            add(1, 0, 1, 0, 3'b000, (i == 2) ? 1'b1 : 1'b0);
            add(0, 0, 1, 0, 3'b000, 0);
            add(0, 0, 1, 0, 3'b000, 0);
        end

        // Reset state.
        @(posedge clock);
        #1;
        check("reset_ind", {31'd0, indicator}, 32'd0);
`ifdef DETECT_PATTERN_CNT_EN
        check("reset_cnt", {30'd0, match_count}, 32'd0);
`endif
        reset = 1'b1;

        foreach (tbl[k]) begin
            step($sformatf("vec%0d", k), tbl[k].valid, tbl[k].bitv, tbl[k].ovl,
                 tbl[k].load, tbl[k].data, tbl[k].exp_ind);
        end

        // Async reset mid-stream after two zeros (pattern still 000).
        step("rst_a0", 0, 0, 1, 1, 3'b000, 0);
        step("rst_a1", 1, 0, 1, 0, 3'b000, 0);
        step("rst_a2", 1, 0, 1, 0, 3'b000, 0);
        #2 reset = 1'b0;
        #1 check("rst_async_ind", {31'd0, indicator}, 32'd0);
        @(posedge clock);
        #3 reset = 1'b1;
        step("rst_b1", 1, 0, 1, 0, 3'b000, 0);
        step("rst_b2", 1, 0, 1, 0, 3'b000, 0);
        step("rst_b3", 1, 0, 1, 0, 3'b000, 1);
        // Reset kills an indicator pulse in flight.
        step("rst_c1", 1, 0, 1, 0, 3'b000, 1);
        #2 reset = 1'b0;
        #1 check("rst_inflight", {31'd0, indicator}, 32'd0);
        @(posedge clock);
        #3 reset = 1'b1;

        // pat_load with bit_valid: the bit is discarded, so 3 more zeros needed.
        step("ld_v0", 1, 0, 1, 1, 3'b000, 0);
        step("ld_v1", 1, 0, 1, 0, 3'b000, 0);
        step("ld_v2", 1, 0, 1, 0, 3'b000, 0);
        step("ld_v3", 1, 0, 1, 0, 3'b000, 1);

`ifdef DETECT_PATTERN_CNT_EN
        count_clr = 1'b1;
        step("cnt_clr_idle", 0, 0, 1, 0, 3'b000, 0);
        check("cnt_zero", {30'd0, match_count}, 32'd0);
        count_clr = 1'b0;
        step("cnt_ld", 0, 0, 1, 1, 3'b000, 0);
        for (int i = 0; i < 7; i++)
            step($sformatf("cnt_b%0d", i), 1, 0, 1, 0, 3'b000, (i >= 2) ? 1'b1 : 1'b0);
        check("cnt_sat", {30'd0, match_count}, 32'd3);
        count_clr = 1'b1;
        step("cnt_clr_match", 1, 0, 1, 0, 3'b000, 1);
        check("cnt_clr_wins", {30'd0, match_count}, 32'd0);
        count_clr = 1'b0;
        step("cnt_after", 1, 0, 1, 0, 3'b000, 1);
        check("cnt_one", {30'd0, match_count}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/detect_pattern_seq.md
Name: detect_pattern_seq

Overview:
Parametrised serial pattern detector and the successor to the fixed three-zero detector. It compares a qualified serial bit stream against a PAT_LEN-bit pattern that can be reloaded at run time, and pulses `indicator` on each match. Overlapping and non-overlapping match modes are supported. It sits directly on the serial input path of the lesson datapath, feeding the control logic.

Parameters:
PAT_LEN, 3, pattern length in bits; legal range 2..32; values outside the range are an elaboration error.
PATTERN, 0 (PAT_LEN'b0), reset value of the pattern register; bit PAT_LEN-1 is the oldest bit, bit 0 the newest.
CNT_W, 8, width of the match counter (optional feature only).

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
bitin  in  1  serial data bit, sampled only when bit_valid=1.
bit_valid  in  1  qualifies bitin for this cycle.
overlap_en  in  1  1 = overlapping matches; 0 = non-overlapping matches.
pat_load  in  1  load pat_data into the pattern register.
pat_data  in  PAT_LEN  new pattern value.
indicator  out  1  registered match pulse.

Behaviour:
- Internal state:
  - hist[PAT_LEN-1:0], shift history, newest bit at bit 0.
  - fill, counter of width clog2(PAT_LEN+1), saturating at PAT_LEN.
  - pat_reg[PAT_LEN-1:0], the active pattern.
- Reset (reset=0, asynchronous): hist=0, fill=0, pat_reg=PATTERN, indicator=0. Release is synchronous to the next edge; the first bit is accepted on the first edge with reset=1.
- Priority at each edge: pat_load > bit_valid > idle.
- pat_load=1:
  - pat_reg<=pat_data, hist<=0, fill<=0, indicator<=0.
  - bitin is discarded even if bit_valid=1.
- bit_valid=1 (and pat_load=0):
  - Form cand={hist[PAT_LEN-2:0],bitin}; then hist<=cand.
  - match = (fill>=PAT_LEN-1) && (cand==pat_reg).
  - indicator<=match.
  - fill<=min(fill+1,PAT_LEN).
  - If match and overlap_en=0: fill<=0 instead, so the next match needs PAT_LEN fresh bits. hist still updates.
- bit_valid=0 (and pat_load=0): hist and fill hold; indicator<=0.
- Pulse width and latency:
  - indicator is high for exactly the one cycle following the edge that accepted the completing bit.
  - With bit_valid held high, consecutive matches give indicator high on consecutive cycles.
  - Latency is 1 cycle from bit acceptance to indicator.
- Fill rule: no match is reported until PAT_LEN bits have been accepted since reset or pat_load. This applies even when the pattern is all-zero and hist=0.
- overlap_en may change on any cycle; the value sampled at the matching edge applies.
- Reset asserted mid-stream clears everything immediately, including an indicator pulse in flight.

Optional Feature:
DETECT_PATTERN_CNT_EN.
- Defined: adds two ports.
  - count_clr  in  1: synchronous clear of the match counter.
  - match_count  out  CNT_W: number of matches.
- Counter rules when defined:
  - match_count increments on every edge where match=1.
  - It saturates at all-ones and does not wrap.
  - count_clr=1 clears it, with priority over an increment on the same edge.
  - Reset clears it; pat_load does not.
- Not defined: both ports and the counter are absent; indicator behaviour is identical.

Test Plan:
1. Defaults (PAT_LEN=3, PATTERN=000), overlap_en=1, bit_valid=1 every cycle, stream 1,1,0,0,1,0,0,0,1,1,0,0,0,0,0 -> indicator high only after bits 8, 13, 14 and 15.
2. Same stream with overlap_en=0 -> indicator high after bits 8 and 13 only; an appended extra 0 (bit 16) then matches.
3. Pattern 101 loaded via pat_load, stream 1,0,1,0,1 -> overlap_en=1: pulses after bits 3 and 5; overlap_en=0: pulse after bit 3 only.
4. Stream 0,0,0 with bit_valid deasserted for 2 cycles between every bit -> single indicator pulse, one cycle long, after the third accepted 0; indicator=0 during all gap cycles.
5. reset pulled low mid-stream after bits 0,0 (async, between edges), then released and bit 0 sent -> no match; match only after 3 fresh zeros. pat_load asserted together with bit_valid -> that bit is ignored.
6. With DETECT_PATTERN_CNT_EN, CNT_W=2: 5 matches -> match_count=3 (saturated). count_clr asserted on the same edge as a match -> match_count=0.
